// File: rtl/input_debouncer_if.sv
// Bundles the debouncer's data-side signals: raw input in, clean level out.
// Latency: none (wires only).
// Backpressure: none; level signals, no handshake.
//
// Signals:
//   raw_in  raw asynchronous input (bouncing), driven by master
//   x_out   debounced level, driven by slave
//   busy    candidate level change being qualified, driven by slave
//   rise_p  1-cycle pulse on x_out 0->1 (DEBOUNCE_EDGE_EN builds only)
//   fall_p  1-cycle pulse on x_out 1->0 (DEBOUNCE_EDGE_EN builds only)
// Optional feature macro: DEBOUNCE_EDGE_EN
interface input_debouncer_if;
  logic raw_in;
  logic x_out;
  logic busy;
`ifdef DEBOUNCE_EDGE_EN
  logic rise_p;
  logic fall_p;

  modport master (output raw_in, input x_out, input busy, input rise_p, input fall_p);
  modport slave  (input raw_in, output x_out, output busy, output rise_p, output fall_p);
`else
  modport master (output raw_in, input x_out, input busy);
  modport slave  (input raw_in, output x_out, output busy);
`endif
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces one raw asynchronous input into a clean level.
// Latency: a clean raw_in step reaches x_out SYNC_STAGES+STABLE_CYCLES edges later.
// Backpressure: none; the output is a level, sampled every cycle.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-low reset
//   dbi     input_debouncer_if.slave: raw_in in; x_out, busy (and rise_p/fall_p) out
// Optional feature macro: DEBOUNCE_EDGE_EN (adds registered rise_p/fall_p pulses)
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   CNT_WIDTH     = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input_debouncer_if.slave dbi
);

  localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

  // Elaboration-time parameter sanity check.
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_param
    $error("input_debouncer: illegal parameters SYNC_STAGES=%0d STABLE_CYCLES=%0d CNT_WIDTH=%0d",
           SYNC_STAGES, STABLE_CYCLES, CNT_WIDTH);
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Encoding chosen so bit 1 is the accepted level and bit 0 flags qualification.
  typedef enum logic [1:0] {
    ST_LO   = 2'b00,
    WAIT_HI = 2'b01,
    ST_HI   = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   x_q;
  logic                   x_nxt;
  logic                   busy;

  // Synchronizer chain; only the last flop feeds the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dbi.raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // FSM state register, stability counter and registered level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (RESET_LEVEL) begin
        state_q <= ST_HI;
      end else begin
        state_q <= ST_LO;
      end
      cnt_q <= '0;
      x_q   <= RESET_LEVEL;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      x_q     <= x_nxt;
    end
  end

  // Next-state logic. A sample matching the current level aborts a
  // qualification; the count restarts from 1 on the next opposite sample.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_LO: begin
        if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_nxt = state_q;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: busy from the current state, next x_out from the next
  // state so x_out is registered yet tracks state exactly.
  always_comb begin
    busy  = 1'b0;
    x_nxt = 1'b0;
    case (state_q)
      WAIT_HI, WAIT_LO: busy = 1'b1;
      default:          busy = 1'b0;
    endcase
    case (state_nxt)
      ST_HI, WAIT_LO: x_nxt = 1'b1;
      default:        x_nxt = 1'b0;
    endcase
  end

  assign dbi.x_out = x_q;
  assign dbi.busy  = busy;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses share the edge on which x_out changes; x_q and x_nxt cannot
  // differ in both directions at once, so the two never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= !x_q &&  x_nxt;
      fall_q <=  x_q && !x_nxt;
    end
  end

  assign dbi.rise_p = rise_q;
  assign dbi.fall_p = fall_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=1).
// Stimulus pushes expected output snapshots keyed by clock-edge count; the
// monitor pops them on the falling edge and flags any unscheduled output change.
module tb_input_debouncer;

  typedef struct {
    int    cyc;
    logic  x;
    logic  b;
    logic  r;
    logic  f;
    string name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   done = 1'b0;
  bit   finished = 1'b0;
  exp_t exp_q[$];

  input_debouncer_if dif();

  input_debouncer #(
    .SYNC_STAGES  (2),
    .CNT_WIDTH    (16),
    .STABLE_CYCLES(4),
    .RESET_LEVEL  (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dbi  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic x, input logic b,
                               input logic r, input logic f, input string name);
    exp_t e;
    e.cyc = c; e.x = x; e.b = b; e.name = name;
`ifdef DEBOUNCE_EDGE_EN
    e.r = r; e.f = f;
`else
    e.r = 1'b0; e.f = 1'b0;
`endif
    exp_q.push_back(e);
  endfunction

  // Monitor / scoreboard.
  logic [3:0] cur;
  logic [3:0] prev;
  bit         have_prev = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
`ifdef DEBOUNCE_EDGE_EN
    cur = {dif.x_out, dif.busy, dif.rise_p, dif.fall_p};
`else
    cur = {dif.x_out, dif.busy, 2'b00};
`endif
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total = total + 1;
      $display("FAIL %s: expectation for edge %0d never matched (now edge %0d)", e.name, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      total = total + 1;
      if (cur == {e.x, e.b, e.r, e.f}) begin
        passed = passed + 1;
      end else begin
        $display("FAIL %s @edge %0d: got x=%b busy=%b rise=%b fall=%b, want x=%b busy=%b rise=%b fall=%b",
                 e.name, cyc, cur[3], cur[2], cur[1], cur[0], e.x, e.b, e.r, e.f);
      end
    end else if (have_prev && cur != prev) begin
      total = total + 1;
      $display("FAIL unexpected_change @edge %0d: got x=%b busy=%b rise=%b fall=%b, want x=%b busy=%b rise=%b fall=%b",
               cyc, cur[3], cur[2], cur[1], cur[0], prev[3], prev[2], prev[1], prev[0]);
    end
    prev      = cur;
    have_prev = 1'b1;
    if (done && !finished) begin
      total = total + 1;
      if (exp_q.size() == 0) passed = passed + 1;
      else $display("FAIL queue_drained: got %0d pending, want 0", exp_q.size());
      finished = 1'b1;
    end
  end

  task automatic wait_cyc(input int c);
    int n;
    n = c - cyc;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Clean step to lvl from the opposite settled level.
  task automatic clean_step(input logic lvl, input string name);
    int k;
    k = cyc;
    dif.raw_in = lvl;
    push(k + 3, !lvl, 1'b1, 1'b0, 1'b0, {name, "_busy"});
    push(k + 6,  lvl, 1'b0, lvl, !lvl, {name, "_accept"});
    push(k + 7,  lvl, 1'b0, 1'b0, 1'b0, {name, "_pulse_end"});
    wait_cyc(k + 8);
  endtask

  initial begin
    int    k;
    logic  bounce [5];
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset      = 1'b1;
    dif.raw_in = 1'b0;
    #1 reset   = 1'b0;

    // Reset state, then release with raw_in low.
    push(1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_state");
    wait_cyc(3);
    reset = 1'b1;
    push(6,  1'b1, 1'b1, 1'b0, 1'b0, "release_busy");
    push(9,  1'b0, 1'b0, 1'b0, 1'b1, "release_accept");
    push(10, 1'b0, 1'b0, 1'b0, 1'b0, "release_pulse_end");
    wait_cyc(11);

    clean_step(1'b1, "rise1");

    // Short low glitch is rejected.
    k = cyc;
    dif.raw_in = 1'b0;
    push(k + 3, 1'b1, 1'b1, 1'b0, 1'b0, "glitch_busy");
    push(k + 5, 1'b1, 1'b0, 1'b0, 1'b0, "glitch_reject");
    wait_cyc(k + 2);
    dif.raw_in = 1'b1;
    wait_cyc(k + 8);

    clean_step(1'b0, "fall_step");
    clean_step(1'b1, "rise2");

    // Bounce 0,1,0,1,0 then steady 0.
    k = cyc;
    push(k + 3,  1'b1, 1'b1, 1'b0, 1'b0, "bounce_wait1");
    push(k + 4,  1'b1, 1'b0, 1'b0, 1'b0, "bounce_rej1");
    push(k + 5,  1'b1, 1'b1, 1'b0, 1'b0, "bounce_wait2");
    push(k + 6,  1'b1, 1'b0, 1'b0, 1'b0, "bounce_rej2");
    push(k + 7,  1'b1, 1'b1, 1'b0, 1'b0, "bounce_wait3");
    push(k + 10, 1'b0, 1'b0, 1'b0, 1'b1, "bounce_accept");
    push(k + 11, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_pulse_end");
    for (int i = 0; i < 5; i++) begin
      dif.raw_in = bounce[i];
      wait_cyc(k + i + 1);
    end
    wait_cyc(k + 12);

    clean_step(1'b1, "rise3");

    // Reset while in WAIT_LO with cnt=2 discards the pending change.
    k = cyc;
    dif.raw_in = 1'b0;
    push(k + 3,  1'b1, 1'b1, 1'b0, 1'b0, "midq_busy");
    push(k + 4,  1'b1, 1'b0, 1'b0, 1'b0, "midq_reset");
    push(k + 12, 1'b1, 1'b0, 1'b0, 1'b0, "midq_hold");
    wait_cyc(k + 4);
    reset      = 1'b0;
    dif.raw_in = 1'b1;
    wait_cyc(k + 6);
    reset = 1'b1;
    wait_cyc(k + 14);

    done = 1'b1;
    for (int i = 0; i < 10 && !finished; i++) @(posedge clk);
    if (!finished) begin
      total = total + 1;
      $display("FAIL monitor_done: got unfinished, want finished");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at edge %0d, want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
